// File: rtl/cpu_run_sequencer.sv
// cpu_run_sequencer: load-then-run control sequencer for the 8-bit CPU.
// A LOAD phase streams host bytes into instruction memory; start then walks
// the PC through FETCH/DECODE/EXEC/WB until a HALT opcode or program end.
// Optional feature macro: CPU_SINGLE_STEP_EN (adds the step port; FETCH
// waits for a step pulse before loading the IR).
module cpu_run_sequencer #(
  parameter int         ADDR_W  = 4,
  parameter logic [7:0] HALT_OP = 8'hFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [7:0]        load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic              start,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [7:0]        imem_wdata,
  output logic [ADDR_W-1:0] imem_raddr,
  input  logic [7:0]        imem_rdata,
  output logic [7:0]        instruction,
  output logic              ir_load,
  output logic              reg_rd_en,
  output logic              alu_en,
  output logic              reg_wr_en,
  output logic              busy,
  output logic              done
`ifdef CPU_SINGLE_STEP_EN
  ,
  input  logic              step
`endif
);

  typedef enum logic [2:0] {
    S_LOAD   = 3'd0,
    S_IDLE   = 3'd1,
    S_FETCH  = 3'd2,
    S_DECODE = 3'd3,
    S_EXEC   = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [ADDR_W:0]   FULL_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] LAST_PTR = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ZERO_PTR = {ADDR_W{1'b0}};
  localparam logic [ADDR_W:0]   ZERO_LEN = {(ADDR_W+1){1'b0}};

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] wptr_r, wptr_s;
  logic [ADDR_W:0]   len_r, len_s;
  logic [ADDR_W-1:0] pc_r, pc_s;
  logic [7:0]        ir_r, ir_s;
  logic              accept_s;
  logic              step_ok_s;

`ifdef CPU_SINGLE_STEP_EN
  assign step_ok_s = step;
`else
  assign step_ok_s = 1'b1;
`endif

  // A byte is taken whenever the host offers one while we are in LOAD.
  assign accept_s = (state_r == S_LOAD) && load_valid;

  // Next-state and register-update logic for the sequencer.
  always_comb begin
    state_s = state_r;
    wptr_s  = wptr_r;
    len_s   = len_r;
    pc_s    = pc_r;
    ir_s    = ir_r;
    case (state_r)
      S_LOAD: begin
        if (accept_s) begin
          wptr_s = wptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
          if (load_last) begin
            len_s   = {1'b0, wptr_r} + {{ADDR_W{1'b0}}, 1'b1};
            state_s = S_IDLE;
          end else if (wptr_r == LAST_PTR) begin
            // Memory full: end the load rather than wrap and overwrite.
            len_s   = FULL_LEN;
            state_s = S_IDLE;
          end else begin
            state_s = S_LOAD;
          end
        end else if (start && (wptr_r == ZERO_PTR)) begin
          // No byte accepted yet: a start runs the empty program, which
          // halts at once. Once loading has begun, start is ignored.
          pc_s    = ZERO_PTR;
          state_s = S_HALT;
        end else begin
          state_s = S_LOAD;
        end
      end
      S_IDLE, S_HALT: begin
        if (start) begin
          pc_s    = ZERO_PTR;
          state_s = (len_r == ZERO_LEN) ? S_HALT : S_FETCH;
        end else if (load_valid) begin
          // Re-enter LOAD; the offered byte is taken on the next cycle.
          wptr_s  = ZERO_PTR;
          len_s   = ZERO_LEN;
          state_s = S_LOAD;
        end else begin
          state_s = state_r;
        end
      end
      S_FETCH: begin
        if (step_ok_s) begin
          ir_s    = imem_rdata;
          state_s = S_DECODE;
        end else begin
          state_s = S_FETCH;
        end
      end
      S_DECODE: begin
        if (ir_r == HALT_OP) begin
          state_s = S_HALT;
        end else begin
          state_s = S_EXEC;
        end
      end
      S_EXEC: begin
        state_s = S_WB;
      end
      S_WB: begin
        pc_s = pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        if (({1'b0, pc_r} + {{ADDR_W{1'b0}}, 1'b1}) == len_r) begin
          state_s = S_HALT;
        end else begin
          state_s = S_FETCH;
        end
      end
      default: begin
        state_s = S_LOAD;
      end
    endcase
  end

  // State and datapath-control registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= S_LOAD;
      wptr_r  <= {ADDR_W{1'b0}};
      len_r   <= {(ADDR_W+1){1'b0}};
      pc_r    <= {ADDR_W{1'b0}};
      ir_r    <= 8'h00;
    end else begin
      state_r <= state_s;
      wptr_r  <= wptr_s;
      len_r   <= len_s;
      pc_r    <= pc_s;
      ir_r    <= ir_s;
    end
  end

  // Output decode: phase enables come straight from the state register so
  // they drop to zero the instant reset clears it.
  always_comb begin
    load_ready  = (state_r == S_LOAD);
    imem_we     = accept_s;
    imem_waddr  = wptr_r;
    imem_wdata  = accept_s ? load_data : 8'h00;
    imem_raddr  = pc_r;
    instruction = ir_r;
    ir_load     = (state_r == S_FETCH) && step_ok_s;
    reg_rd_en   = (state_r == S_DECODE);
    alu_en      = (state_r == S_EXEC);
    // Class 2'b11 opcodes are NOPs with no register writeback.
    reg_wr_en   = (state_r == S_WB) && (ir_r[7:6] != 2'b11);
    busy        = (state_r == S_FETCH) || (state_r == S_DECODE) ||
                  (state_r == S_EXEC)  || (state_r == S_WB);
    done        = (state_r == S_HALT);
  end

endmodule

// File: tb/tb_cpu_run_sequencer.sv
// Scoreboard testbench for cpu_run_sequencer: stimulus pushes expected
// writes, fetches, executes, writebacks and completion into queues; a
// negedge monitor pops and compares whenever the DUT raises an event.
module tb_cpu_run_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_last;
  logic       load_ready;
  logic       start;
  logic       imem_we;
  logic [3:0] imem_waddr;
  logic [7:0] imem_wdata;
  logic [3:0] imem_raddr;
  logic [7:0] imem_rdata;
  logic [7:0] instruction;
  logic       ir_load, reg_rd_en, alu_en, reg_wr_en, busy, done;
`ifdef CPU_SINGLE_STEP_EN
  logic       step = 1'b1;
`endif

  cpu_run_sequencer dut (
    .clk(clk), .reset(reset),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(load_ready), .start(start),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .imem_raddr(imem_raddr), .imem_rdata(imem_rdata),
    .instruction(instruction), .ir_load(ir_load), .reg_rd_en(reg_rd_en),
    .alu_en(alu_en), .reg_wr_en(reg_wr_en), .busy(busy), .done(done)
`ifdef CPU_SINGLE_STEP_EN
    , .step(step)
`endif
  );

  always #5 clk = ~clk;

  // Instruction memory: synchronous write, asynchronous read.
  logic [7:0] mem [16];
  assign imem_rdata = mem[imem_raddr];
  always @(posedge clk) if (imem_we) mem[imem_waddr] <= imem_wdata;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  logic [31:0] q_wr[$], q_fetch[$], q_exec[$], q_wb[$], q_done[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic miss(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got a DUT event, required none", name);
  endtask

  function automatic logic [31:0] outs();
    return {load_ready, imem_we, imem_waddr, imem_wdata, imem_raddr, instruction,
            ir_load, reg_rd_en, alu_en, reg_wr_en, busy, done};
  endfunction

  // Monitor: every DUT event is matched against the head of its queue.
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      if (imem_we) begin
        if (q_wr.size() == 0) miss("write");
        else check("write_addr_data", {20'h0, imem_waddr, imem_wdata}, q_wr.pop_front());
      end
      if (ir_load) begin
        if (q_fetch.size() == 0) miss("fetch");
        else check("fetch_pc", {28'h0, imem_raddr}, q_fetch.pop_front());
      end
      if (alu_en) begin
        if (q_exec.size() == 0) miss("exec");
        else check("exec_ir", {24'h0, instruction}, q_exec.pop_front());
      end
      if (reg_wr_en) begin
        if (q_wb.size() == 0) miss("writeback");
        else check("wb_ir", {24'h0, instruction}, q_wb.pop_front());
      end
      if (done && !done_prev) begin
        if (q_done.size() == 0) miss("done");
        else check("done_cycle_pc", (32'(cyc) << 8) | {28'h0, imem_raddr}, q_done.pop_front());
      end
      done_prev <= done;
    end else begin
      done_prev <= 1'b0;
    end
  end

  // Reference model: walk the program by the ISA rules and predict events.
  task automatic model_run(input logic [7:0] prog[$], input int len, input int t0);
    int pc;
    int lat;
    pc  = 0;
    lat = 1;
    if (len > 0) begin
      while (1) begin
        q_fetch.push_back(32'(pc));
        if (prog[pc] == 8'hFF) begin
          lat += 2;
          break;
        end
        q_exec.push_back(32'(prog[pc]));
        if (prog[pc][7:6] != 2'b11) q_wb.push_back(32'(prog[pc]));
        lat += 4;
        pc++;
        if (pc == len) break;
      end
    end
    q_done.push_back((32'(t0 + lat) << 8) | 32'(pc % 16));
  endtask

  task automatic clear_queues();
    q_wr.delete(); q_fetch.delete(); q_exec.delete(); q_wb.delete(); q_done.delete();
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic load_prog(input logic [7:0] prog[$], input bit forced);
    if (!load_ready) begin
      load_valid = 1'b1; load_data = 8'hA5; load_last = 1'b1;
      #1 check("reentry_no_write", 32'(imem_we), 32'd0);
      @(posedge clk); #1;
      load_valid = 1'b0; load_last = 1'b0;
      check("reentry_ready", 32'(load_ready), 32'd1);
    end
    for (int i = 0; i < prog.size(); i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      load_valid = 1'b1;
      load_data  = prog[i];
      load_last  = (i == prog.size() - 1) && !forced;
      q_wr.push_back({20'h0, 4'(i), prog[i]});
      @(posedge clk); #1;
      load_valid = 1'b0; load_last = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (q_done.size() != 0 && k < 300) begin @(posedge clk); k++; end
    #1;
    check("run_timeout", 32'(q_done.size()), 32'd0);
    check("leftover_events", 32'(q_wr.size() + q_fetch.size() + q_exec.size() + q_wb.size()), 32'd0);
    check("halted", {30'h0, done, busy}, 32'd2);
  endtask

  task automatic run_prog(input logic [7:0] prog[$], input int len, input bit with_lv);
    start = 1'b1; load_valid = with_lv; load_data = 8'h77;
    model_run(prog, len, cyc);
    @(posedge clk); #1;
    start = 1'b0; load_valid = 1'b0;
    wait_drain();
  endtask

  logic [7:0] prog[$];
  logic [7:0] none[$];

  initial begin
    int n;
    reset = 1'b0; load_valid = 1'b0; load_data = 8'h00; load_last = 1'b0; start = 1'b0;
    @(posedge clk); #3;
    check("reset_outputs", outs(), 32'h8000_0000);
    @(posedge clk); #1;
    reset = 1'b1;

    // Empty program: start straight after reset halts in one cycle.
    start = 1'b1;
    model_run(none, 0, cyc);
    @(posedge clk); #1;
    start = 1'b0;
    check("empty_done_busy", {30'h0, done, busy}, 32'd2);
    repeat (2) begin @(posedge clk); #1; check("empty_busy", 32'(busy), 32'd0); end
    wait_drain();

    // Load and run three ordinary instructions.
    prog = '{8'h12, 8'h45, 8'h8A};
    load_prog(prog, 1'b0);
    run_prog(prog, 3, 1'b0);

    // HALT opcode in the middle; the byte after it is never fetched.
    prog = '{8'h01, 8'hFF, 8'h02};
    load_prog(prog, 1'b0);
    run_prog(prog, 3, 1'b0);

    // Class-11 NOP: executes but writes nothing back; re-run from HALT with
    // start and load_valid together.
    prog = '{8'hC3};
    load_prog(prog, 1'b0);
    run_prog(prog, 1, 1'b0);
    run_prog(prog, 1, 1'b1);

    // Full depth: 16 bytes without last force the end of the load.
    prog.delete();
    for (int i = 0; i < 16; i++) prog.push_back(8'(i * 8'h11 + 8'h03) & 8'h7F);
    load_prog(prog, 1'b1);
    check("full_not_ready", 32'(load_ready), 32'd0);
    load_valid = 1'b1; load_data = 8'hEE;
    #1 check("no_17th_write", 32'(imem_we), 32'd0);
    @(posedge clk); #1;
    load_valid = 1'b0;
    check("no_wrap_overwrite", 32'(mem[0]), 32'(prog[0]));
    load_prog(prog, 1'b1);
    run_prog(prog, 16, 1'b0);

    // Reset during EXEC of the second instruction.
    prog = '{8'h12, 8'h45, 8'h8A};
    load_prog(prog, 1'b0);
    start = 1'b1;
    model_run(prog, 3, cyc);
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    for (int k = 0; k < 20 && n < 2; k++) begin
      @(negedge clk);
      if (alu_en) n++;
    end
    check("reached_second_exec", 32'(n), 32'd2);
    #1 reset = 1'b0;
    #1 check("midexec_reset_outputs", outs(), 32'h8000_0000);
    clear_queues();
    @(posedge clk); #1;
    reset = 1'b1;

    // Randomized programs against the model.
    for (int t = 0; t < 25; t++) begin
      bit forced;
      int len;
      len = $urandom_range(1, 16);
      forced = (len == 16) && ($urandom_range(0, 1) == 1);
      prog.delete();
      for (int i = 0; i < len; i++) begin
        case ($urandom_range(0, 7))
          0:       prog.push_back(8'hFF);
          1:       prog.push_back({2'b11, 6'($urandom_range(0, 63))});
          default: prog.push_back(8'($urandom_range(0, 255)));
        endcase
      end
      load_prog(prog, forced);
      run_prog(prog, len, 1'b0);
      if ($urandom_range(0, 2) == 0) run_prog(prog, len, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, required to finish");
    $fatal(1, "timeout");
  end

endmodule
